lbc_cbus_arb: RTL and testbench

LBC_CBUS_ARB -- requirements
Module: lbc_cbus_arb

---
 rtl/lbc_cbus_arb.sv | 197 +++++++++++++++++++
 tb/tb_lbc_cbus_arb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbc_cbus_arb.sv
// Command-bus arbiter: picks one read/fetch channel or the posted-write buffer,
// issues a go to the far side and waits for completion or timeout.
module lbc_cbus_arb #(
    parameter int NCH    = 4,
    parameter int WDEPTH = 4,
    parameter int RRMODE = 0,
    parameter int TMOCYC = 255
) (
    input  logic                      SYSCLK,
    input  logic                      RESET_D1_R,
    input  logic                      LBCSYNCMODE,
    input  logic [NCH-1:0]            CH_REQ,
    input  logic                      CBUS_WREQ,
    input  logic                      LDN_CGOACK_R,
    output logic                      LC_CGO,
    output logic                      LC_GOTOGGLE_R,
    output logic [NCH:0]              LC_CQSEL,
    output logic [NCH-1:0]            LC_CHLOAD,
    output logic                      LC_FWLOAD,
    output logic                      LC_FWSHIFT,
    output logic                      CBUS_HALT_W_R,
    output logic [NCH-1:0]            LC_PEND_R,
    output logic                      LC_BUSY_R,
    output logic [$clog2(WDEPTH):0]   LC_WCOUNT_R,
    output logic                      LC_TIMEOUT_R,
    output logic                      LC_WDROP_R
);

    localparam int WCW  = $clog2(WDEPTH) + 1;
    localparam int IDXW = $clog2(NCH);
    localparam logic [7:0] TMO = 8'(TMOCYC);

    typedef enum logic {
        IDLE  = 1'b0,
        GOING = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             toggle_q, toggle_d;
    logic [NCH:0]     sel_q, sel_d, sel_new;
    logic [NCH-1:0]   pend_q, pend_d;
    logic [IDXW-1:0]  last_q, last_d;
    logic [7:0]       tcnt_q, tcnt_d;
    logic [WCW-1:0]   wcount_q, wcount_d;
    logic             halt_q, halt_d;
    logic             tmo_q, tmo_d;
    logic             wdrop_q, wdrop_d;

    logic             run;
    logic [NCH-1:0]   cand;
    logic [NCH-1:0]   clear;
    logic [IDXW-1:0]  pick;
    logic             found;
    logic             full;
    logic             wsel;
    logic             launch;
    logic             ack_done;
    logic             tmo_hit;
    logic             done;
    logic             fwload;
    logic             fwshift;

    assign run  = ~RESET_D1_R;
    assign cand = pend_q | CH_REQ;
    assign full = (wcount_q == WCW'(WDEPTH));

    // Channel choice among pending-or-requesting channels.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        if (RRMODE != 0) begin
            for (int j = 1; j <= NCH; j++) begin
                int idx;
                idx = (int'(last_q) + j) % NCH;
                if (!found && cand[idx]) begin
                    found = 1'b1;
                    pick  = IDXW'(idx);
                end
            end
        end else begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (cand[i]) begin
                    found = 1'b1;
                    pick  = IDXW'(i);
                end
            end
        end
    end

    always_comb begin
        wsel = full || (cand == '0);
        sel_new = '0;
        sel_new[NCH] = wsel;
        for (int i = 0; i < NCH; i++) begin
            sel_new[i] = !wsel && found && (pick == IDXW'(i));
        end
    end

    always_comb begin
        state_d  = state_q;
        toggle_d = toggle_q;
        sel_d    = sel_q;
        last_d   = last_q;
        tcnt_d   = tcnt_q;
        launch   = 1'b0;
        ack_done = 1'b0;
        tmo_hit  = 1'b0;

        case (state_q)
            IDLE: begin
                if (run && ((cand != '0) || (wcount_q != '0))) begin
                    launch   = 1'b1;
                    state_d  = GOING;
                    toggle_d = ~toggle_q;
                    sel_d    = sel_new;
                    tcnt_d   = 8'd0;
                    if (!wsel) begin
                        last_d = pick;
                    end
                end
            end
            GOING: begin
                if (run) begin
                    // An ack in the timeout cycle wins and suppresses the pulse.
                    if (LDN_CGOACK_R) begin
                        ack_done = 1'b1;
                    end else if ((TMOCYC != 0) && ((tcnt_q + 8'd1) == TMO)) begin
                        tmo_hit = 1'b1;
                    end
                    if (ack_done || tmo_hit) begin
                        state_d = IDLE;
                        tcnt_d  = 8'd0;
                    end else begin
                        tcnt_d  = tcnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        done    = ack_done | tmo_hit;
        clear   = done ? sel_q[NCH-1:0] : '0;
        pend_d  = CH_REQ | (pend_q & ~clear);
        fwshift = done & sel_q[NCH];
        fwload  = run & CBUS_WREQ & ~full;
        wdrop_d = run & CBUS_WREQ & full & ~fwshift;
        tmo_d   = tmo_hit;

        wcount_d = wcount_q;
        if (fwload && !fwshift) begin
            wcount_d = wcount_q + WCW'(1);
        end else if (fwshift && !fwload && (wcount_q != '0)) begin
            wcount_d = wcount_q - WCW'(1);
        end
        halt_d = (wcount_d == WCW'(WDEPTH));
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET_D1_R) begin
            state_q  <= IDLE;
            toggle_q <= 1'b0;
            sel_q    <= '0;
            pend_q   <= '0;
            last_q   <= IDXW'(NCH - 1);
            tcnt_q   <= 8'd0;
            wcount_q <= '0;
            halt_q   <= 1'b0;
            tmo_q    <= 1'b0;
            wdrop_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            toggle_q <= toggle_d;
            sel_q    <= sel_d;
            pend_q   <= pend_d;
            last_q   <= last_d;
            tcnt_q   <= tcnt_d;
            wcount_q <= wcount_d;
            halt_q   <= halt_d;
            tmo_q    <= tmo_d;
            wdrop_q  <= wdrop_d;
        end
    end

    assign LC_BUSY_R     = (state_q == GOING);
    assign LC_CGO        = LBCSYNCMODE ? LC_BUSY_R : toggle_d;
    assign LC_GOTOGGLE_R = toggle_q;
    assign LC_CQSEL      = launch ? sel_new : sel_q;
    assign LC_CHLOAD     = CH_REQ;
    assign LC_FWLOAD     = fwload;
    assign LC_FWSHIFT    = fwshift;
    assign CBUS_HALT_W_R = halt_q;
    assign LC_PEND_R     = pend_q;
    assign LC_WCOUNT_R   = wcount_q;
    assign LC_TIMEOUT_R  = tmo_q;
    assign LC_WDROP_R    = wdrop_q;

endmodule

// File: tb/tb_lbc_cbus_arb.sv
// Bench for lbc_cbus_arb: a fixed-priority and a round-robin instance share the
// same stimulus and are both compared against a transaction-level model.
module tb_lbc_cbus_arb;

    localparam int NCH = 4;
    localparam int WD  = 4;
    localparam int TMO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, sync, wreq, ack;
    logic [3:0] req;

    logic       cgo[2], tog[2], fwload[2], fwshift[2], halt[2], busy[2], tmo[2], wdrop[2];
    logic [4:0] cqsel[2];
    logic [3:0] chload[2], pend[2];
    logic [2:0] wcount[2];

    lbc_cbus_arb #(.NCH(NCH), .WDEPTH(WD), .RRMODE(0), .TMOCYC(TMO)) dut0 (
        .SYSCLK(clk), .RESET_D1_R(rst), .LBCSYNCMODE(sync), .CH_REQ(req),
        .CBUS_WREQ(wreq), .LDN_CGOACK_R(ack), .LC_CGO(cgo[0]), .LC_GOTOGGLE_R(tog[0]),
        .LC_CQSEL(cqsel[0]), .LC_CHLOAD(chload[0]), .LC_FWLOAD(fwload[0]),
        .LC_FWSHIFT(fwshift[0]), .CBUS_HALT_W_R(halt[0]), .LC_PEND_R(pend[0]),
        .LC_BUSY_R(busy[0]), .LC_WCOUNT_R(wcount[0]), .LC_TIMEOUT_R(tmo[0]),
        .LC_WDROP_R(wdrop[0]));

    lbc_cbus_arb #(.NCH(NCH), .WDEPTH(WD), .RRMODE(1), .TMOCYC(TMO)) dut1 (
        .SYSCLK(clk), .RESET_D1_R(rst), .LBCSYNCMODE(sync), .CH_REQ(req),
        .CBUS_WREQ(wreq), .LDN_CGOACK_R(ack), .LC_CGO(cgo[1]), .LC_GOTOGGLE_R(tog[1]),
        .LC_CQSEL(cqsel[1]), .LC_CHLOAD(chload[1]), .LC_FWLOAD(fwload[1]),
        .LC_FWSHIFT(fwshift[1]), .CBUS_HALT_W_R(halt[1]), .LC_PEND_R(pend[1]),
        .LC_BUSY_R(busy[1]), .LC_WCOUNT_R(wcount[1]), .LC_TIMEOUT_R(tmo[1]),
        .LC_WDROP_R(wdrop[1]));

    int total = 0;
    int bad   = 0;

    // Model state: which source owns the bus (-1 none, NCH = write buffer),
    // how long the transaction has run, and the write-buffer occupancy.
    logic [3:0] m_pend[2], n_pend[2];
    int m_busy[2], m_tog[2], m_sel[2], m_last[2], m_age[2], m_wcnt[2], m_halt[2], m_tmo[2], m_drop[2];
    int n_busy[2], n_tog[2], n_sel[2], n_last[2], n_age[2], n_wcnt[2], n_halt[2], n_tmo[2], n_drop[2];
    int e_cgo[2], e_cqsel[2], e_fwload[2], e_fwshift[2];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", nm, k, $time, act, exp);
        end
    endtask

    function automatic int onehot(input int s);
        onehot = (s < 0) ? 0 : (1 << s);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 4'b0; m_busy[k] = 0; m_tog[k] = 0; m_sel[k] = -1;
            m_last[k] = NCH - 1; m_age[k] = 0; m_wcnt[k] = 0; m_halt[k] = 0;
            m_tmo[k] = 0; m_drop[k] = 0;
        end
    endtask

    task automatic model_eval(input int k);
        logic [3:0] c;
        int launch, newsel, dack, dtmo, done;
        c = m_pend[k] | req;
        launch = (!rst && m_busy[k] == 0 && (c != 0 || m_wcnt[k] != 0)) ? 1 : 0;
        newsel = -1;
        if (m_wcnt[k] == WD || c == 0) newsel = NCH;
        else if (k == 1) begin
            for (int j = 1; j <= NCH; j++)
                if (newsel < 0 && c[(m_last[k] + j) % NCH]) newsel = (m_last[k] + j) % NCH;
        end else begin
            for (int i = NCH - 1; i >= 0; i--) if (c[i]) newsel = i;
        end
        dack = (!rst && m_busy[k] == 1 && ack) ? 1 : 0;
        dtmo = (!rst && m_busy[k] == 1 && !ack && m_age[k] == TMO) ? 1 : 0;
        done = dack | dtmo;
        e_fwshift[k] = (done == 1 && m_sel[k] == NCH) ? 1 : 0;
        e_fwload[k]  = (!rst && wreq && m_wcnt[k] < WD) ? 1 : 0;
        e_cqsel[k]   = onehot(launch == 1 ? newsel : m_sel[k]);
        e_cgo[k]     = sync ? m_busy[k] : (m_tog[k] ^ launch);

        for (int i = 0; i < NCH; i++)
            n_pend[k][i] = req[i] | (m_pend[k][i] & !(done == 1 && m_sel[k] == i));
        n_busy[k] = launch ? 1 : (done ? 0 : m_busy[k]);
        n_tog[k]  = m_tog[k] ^ launch;
        n_sel[k]  = launch ? newsel : m_sel[k];
        n_last[k] = (launch == 1 && newsel < NCH) ? newsel : m_last[k];
        n_age[k]  = launch ? 1 : ((m_busy[k] == 1 && !done) ? m_age[k] + 1 : 0);
        n_wcnt[k] = m_wcnt[k] + e_fwload[k] - ((e_fwshift[k] == 1 && m_wcnt[k] > 0) ? 1 : 0);
        n_halt[k] = (n_wcnt[k] == WD) ? 1 : 0;
        n_tmo[k]  = dtmo;
        n_drop[k] = (!rst && wreq && m_wcnt[k] == WD && e_fwshift[k] == 0) ? 1 : 0;
    endtask

    task automatic settle_check();
        #2;
        for (int k = 0; k < 2; k++) begin
            model_eval(k);
            chk("cgo", k, cgo[k], e_cgo[k]);
            chk("cqsel", k, cqsel[k], e_cqsel[k]);
            chk("chload", k, chload[k], req);
            chk("fwload", k, fwload[k], e_fwload[k]);
            chk("fwshift", k, fwshift[k], e_fwshift[k]);
            chk("toggle", k, tog[k], m_tog[k]);
            chk("busy", k, busy[k], m_busy[k]);
            chk("pend", k, pend[k], m_pend[k]);
            chk("wcount", k, wcount[k], m_wcnt[k]);
            chk("halt", k, halt[k], m_halt[k]);
            chk("timeout", k, tmo[k], m_tmo[k]);
            chk("wdrop", k, wdrop[k], m_drop[k]);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) model_reset();
        else begin
            for (int k = 0; k < 2; k++) begin
                m_pend[k] = n_pend[k]; m_busy[k] = n_busy[k]; m_tog[k] = n_tog[k];
                m_sel[k] = n_sel[k]; m_last[k] = n_last[k]; m_age[k] = n_age[k];
                m_wcnt[k] = n_wcnt[k]; m_halt[k] = n_halt[k]; m_tmo[k] = n_tmo[k];
                m_drop[k] = n_drop[k];
            end
        end
        @(negedge clk);
    endtask

    task automatic cyc(input logic [3:0] r, input logic w, input logic a);
        req = r; wreq = w; ack = a;
        settle_check();
    endtask

    task automatic step(input logic [3:0] r, input logic w, input logic a);
        cyc(r, w, a);
        advance();
    endtask

    int order[4] = '{1, 2, 3, 0};
    int n;

    initial begin
        rst = 1'b1; sync = 1'b0; req = 4'b0; wreq = 1'b0; ack = 1'b0;
        @(negedge clk);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;

        // Reset state
        cyc(4'b0, 1'b0, 1'b0);
        chk("rst_busy", 0, busy[0], 0);
        chk("rst_cqsel", 0, cqsel[0], 0);
        chk("rst_wcount", 0, wcount[0], 0);
        chk("rst_pend", 1, pend[1], 0);
        advance();

        // Fixed priority: 1010 -> ch1 first, ch3 after one idle cycle
        cyc(4'b1010, 1'b0, 1'b0);
        chk("a_launch_sel", 0, cqsel[0], 5'b00010);
        chk("a_cgo", 0, cgo[0], 1);
        chk("a_tog_before", 0, tog[0], 0);
        advance();
        cyc(4'b0, 1'b0, 1'b0);
        chk("a_tog_after", 0, tog[0], 1);
        chk("a_busy", 0, busy[0], 1);
        advance();
        step(4'b0, 1'b0, 1'b1);
        cyc(4'b0, 1'b0, 1'b0);
        chk("a_pend", 0, pend[0], 4'b1000);
        chk("a_idle", 0, busy[0], 0);
        chk("a_relaunch", 0, cqsel[0], 5'b01000);
        advance();
        step(4'b0, 1'b0, 1'b1);
        step(4'b0, 1'b0, 1'b0);

        // Round-robin: grants 0,1,2,3,0
        cyc(4'b1111, 1'b0, 1'b0);
        chk("b_grant0", 1, cqsel[1], 5'b00001);
        advance();
        for (int g = 0; g < 4; g++) begin
            step((g == 3) ? 4'b0001 : 4'b0000, 1'b0, 1'b1);
            cyc(4'b0, 1'b0, 1'b0);
            chk("b_grant", 1, cqsel[1], 5'(1 << order[g]));
            advance();
        end
        step(4'b0001, 1'b0, 1'b1);
        cyc(4'b0, 1'b0, 1'b0);
        chk("b_merge", 1, pend[1], 4'b0001);
        advance();
        step(4'b0, 1'b0, 1'b1);
        step(4'b0, 1'b0, 1'b0);

        // Write buffer fills behind a channel transaction, then wins
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0100, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(4'b0, 1'b1, 1'b0);
        cyc(4'b0, 1'b0, 1'b1);
        chk("c_count", 0, wcount[0], 4);
        chk("c_halt", 0, halt[0], 1);
        chk("c_wdrop", 0, wdrop[0], 1);
        advance();
        cyc(4'b0, 1'b0, 1'b0);
        chk("c_write_wins", 0, cqsel[0], 5'b10000);
        advance();
        cyc(4'b0, 1'b0, 1'b1);
        chk("c_fwshift", 0, fwshift[0], 1);
        advance();
        cyc(4'b0, 1'b0, 1'b0);
        chk("c_chan_wins", 0, cqsel[0], 5'b00100);
        advance();
        for (int i = 0; i < 10; i++) step(4'b0, 1'b0, 1'b1);
        cyc(4'b0, 1'b0, 1'b0);
        chk("c_drained", 0, wcount[0], 0);
        advance();

        // Timeout with no ack
        step(4'b0001, 1'b0, 1'b0);
        n = 0;
        while (busy[0] === 1'b1 && n < 20) begin
            step(4'b0, 1'b0, 1'b0);
            n++;
        end
        cyc(4'b0, 1'b0, 1'b0);
        chk("d_going_cycles", 0, n, TMO);
        chk("d_timeout", 0, tmo[0], 1);
        chk("d_pend_clr", 0, pend[0], 0);
        advance();
        step(4'b0, 1'b0, 1'b0);

        // Ack in the timeout cycle
        step(4'b0001, 1'b0, 1'b0);
        for (int i = 0; i < TMO - 1; i++) step(4'b0, 1'b0, 1'b0);
        step(4'b0, 1'b0, 1'b1);
        cyc(4'b0, 1'b0, 1'b0);
        chk("d_ack_no_tmo", 0, tmo[0], 0);
        chk("d_ack_idle", 0, busy[0], 0);
        advance();

        // Reset mid-write with two entries held
        step(4'b0, 1'b1, 1'b0);
        step(4'b0, 1'b1, 1'b0);
        cyc(4'b0, 1'b0, 1'b0);
        chk("e_count2", 0, wcount[0], 2);
        chk("e_going", 0, busy[0], 1);
        advance();
        rst = 1'b1;
        cyc(4'b0011, 1'b1, 1'b1);
        chk("e_rst_fwshift", 0, fwshift[0], 0);
        advance();
        rst = 1'b0;
        cyc(4'b0, 1'b0, 1'b0);
        chk("e_busy0", 0, busy[0], 0);
        chk("e_wcount0", 0, wcount[0], 0);
        chk("e_halt0", 0, halt[0], 0);
        chk("e_pend0", 0, pend[0], 0);
        chk("e_tog0", 0, tog[0], 0);
        chk("e_cqsel0", 0, cqsel[0], 0);
        chk("e_cgo0", 0, cgo[0], 0);
        advance();

        // Sync mode: go follows busy
        sync = 1'b1;
        cyc(4'b0001, 1'b0, 1'b0);
        chk("f_cgo_launch", 0, cgo[0], 0);
        advance();
        cyc(4'b0, 1'b0, 1'b0);
        chk("f_cgo_busy", 0, cgo[0], 1);
        advance();
        step(4'b0, 1'b0, 1'b1);
        cyc(4'b0, 1'b0, 1'b0);
        chk("f_cgo_idle", 0, cgo[0], 0);
        advance();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
